instr_serial_tx: RTL and testbench
==================================

INSTR_SERIAL_TX -- requirements
Module: instr_serial_tx

Interface
REQ-001 SHALL have parameter WORD_W, default 10, meaning instruction word width in bits.
REQ-002 SHALL have parameter SETUP_CYCLES, default 4, meaning clk cycles data_bit is held stable before data_ready rises.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 5_000_000, meaning max clk cycles spent waiting in either ack phase.
REQ-004 SHALL have port clk  input  1  single system clock, all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port word_in  input  WORD_W  instruction to transmit.
REQ-007 SHALL have port word_valid  input  1  word_in is valid.
REQ-008 SHALL have port word_ready  output  1  high when a word can be accepted.
REQ-009 SHALL have port data_ack  input  1  asynchronous acknowledge from receiver.
REQ-010 SHALL have port data_ready  output  1  bit-present strobe to receiver.
REQ-011 SHALL have port data_bit  output  1  serial data line.
REQ-012 SHALL have port done  output  1  one-cycle pulse, word fully acknowledged.
REQ-013 SHALL have port timeout_err  output  1  one-cycle pulse, transfer aborted.
REQ-014 SHALL have port tx_state  output  3  current FSM state encoding, for debug LEDs.

Function
REQ-015 SHALL synchronise data_ack through two flip-flops before any use; the FSM sees only ack_s.
REQ-016 SHALL implement states IDLE, SETUP, WAIT_ACK_HI, WAIT_ACK_LO, FINISH.
REQ-017 SHALL assert word_ready only in IDLE; in IDLE with word_valid=1 it SHALL latch word_in into a shift register, load bit counter with WORD_W, and go to SETUP.
REQ-018 SHALL transmit MSB first (word_in[WORD_W-1] first, bit 0 last).
REQ-019 SHALL drive data_bit from the shift register MSB continuously; data_bit SHALL change only on entry to SETUP.
REQ-020 In SETUP SHALL keep data_ready=0 for exactly SETUP_CYCLES cycles, then go to WAIT_ACK_HI.
REQ-021 In WAIT_ACK_HI SHALL hold data_ready=1 until ack_s=1, then go to WAIT_ACK_LO.
REQ-022 In WAIT_ACK_LO SHALL hold data_ready=0 until ack_s=0; then it SHALL decrement the bit counter and shift once, going to SETUP if bits remain, else to FINISH.
REQ-023 FINISH SHALL last one cycle, pulse done=1, and return to IDLE; a new word SHALL be accepted no earlier than the cycle after FINISH.
REQ-024 SHALL count cycles in WAIT_ACK_HI and WAIT_ACK_LO (counter cleared on each entry); on reaching ACK_TIMEOUT it SHALL pulse timeout_err, force data_ready=0, discard the word, and return to IDLE.
REQ-025 If ack_s=1 on entry to SETUP (stuck ack), SHALL stay in SETUP with data_ready=0 until ack_s=0; the timeout counter SHALL also run in this case.
REQ-026 word_valid outside IDLE SHALL be ignored; word_in changes mid-transfer SHALL have no effect.
REQ-027 done and timeout_err SHALL never be high in the same cycle.

Reset
REQ-028 On reset=0, SHALL asynchronously force state=IDLE, data_ready=0, data_bit=0, done=0, timeout_err=0, shift register, counters and sync flops to 0.
REQ-029 Reset mid-transfer SHALL abort silently (no done, no timeout_err); word_ready SHALL be 1 in the first cycle after release.

Structure
REQ-030 State encoding, WORD_W default and the handshake timing constants SHALL live in the shared servo-link package used by the receiver.
REQ-031 The 2-FF synchroniser SHALL be a separate sub-module named sync_2ff, reused for other asynchronous inputs.

Verification
REQ-032 word_in=10'b11_1000_0001, receiver model acks after 3 cycles -> 10 handshakes, data_bit sequence 1,1,1,0,0,0,0,0,0,1, one done pulse, word_ready returns to 1.
REQ-033 Every bit: data_bit stable >=SETUP_CYCLES cycles before data_ready rise and until ack_s falls -> no change observed by scoreboard.
REQ-034 Receiver stops acking after bit 4, ACK_TIMEOUT=100 -> timeout_err pulse exactly 100 cycles after WAIT_ACK_HI entry, data_ready=0, IDLE, no done.
REQ-035 data_ack held high at start of word -> data_ready stays 0 until ack released; transfer then completes normally.
REQ-036 reset=0 asserted while in WAIT_ACK_HI at bit 6 -> all outputs 0 immediately, no done/timeout_err; subsequent word 10'h155 transmits correctly.
REQ-037 word_valid held high continuously with changing word_in -> back-to-back words each latched only in IDLE, one done per word.

Source files
------------

// File: rtl/instr_serial_tx_pkg.sv
// Shared servo-link definitions: transmitter FSM encoding, word width and
// handshake timing defaults, common to the transmitter and the receiver.
package instr_serial_tx_pkg;

  localparam int SL_WORD_W       = 10;
  localparam int SL_SETUP_CYCLES = 4;
  localparam int SL_ACK_TIMEOUT  = 5_000_000;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SETUP       = 3'd1,
    ST_WAIT_ACK_HI = 3'd2,
    ST_WAIT_ACK_LO = 3'd3,
    ST_FINISH      = 3'd4
  } tx_state_e;

endpackage

// File: rtl/instr_serial_tx_sync.sv
// Two-flop synchroniser for a single asynchronous input, reset to 0.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/instr_serial_tx.sv
// Bit-serial instruction transmitter: MSB-first, four-phase data_ready /
// data_ack handshake per bit, with setup delay and acknowledge timeout.
module instr_serial_tx
  import instr_serial_tx_pkg::*;
#(
  parameter int WORD_W       = SL_WORD_W,
  parameter int SETUP_CYCLES = SL_SETUP_CYCLES,
  parameter int ACK_TIMEOUT  = SL_ACK_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic              data_ack,
  output logic              data_ready,
  output logic              data_bit,
  output logic              done,
  output logic              timeout_err,
  output logic [2:0]        tx_state
);

  localparam int BC_W = $clog2(WORD_W + 1);
  localparam int SC_W = $clog2(SETUP_CYCLES + 1);
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [BC_W-1:0] BC_LOAD = BC_W'(WORD_W);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETUP_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  tx_state_e         r_state;
  logic [WORD_W-1:0] r_shift;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [SC_W-1:0]   r_setup_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_data_ready;
  logic              r_done;
  logic              r_timeout_err;
  logic              w_ack_s;
  logic              w_to_hit;

  sync_2ff u_ack_sync (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_d     (data_ack),
    .o_q     (w_ack_s)
  );

  assign w_to_hit = (r_to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_setup_cnt   <= '0;
      r_to_cnt      <= '0;
      r_data_ready  <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (word_valid) begin
            r_shift     <= word_in;
            r_bit_cnt   <= BC_LOAD;
            r_setup_cnt <= '0;
            r_to_cnt    <= '0;
            r_state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          // A stuck ack restarts the setup window and runs the timeout instead.
          if (w_ack_s) begin
            r_setup_cnt <= '0;
            if (w_to_hit) begin
              r_timeout_err <= 1'b1;
              r_state       <= ST_IDLE;
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end else if (r_setup_cnt == SC_LAST) begin
            r_data_ready <= 1'b1;
            r_to_cnt     <= '0;
            r_state      <= ST_WAIT_ACK_HI;
          end else begin
            r_setup_cnt <= r_setup_cnt + 1'b1;
          end
        end
        ST_WAIT_ACK_HI: begin
          if (w_ack_s) begin
            r_data_ready <= 1'b0;
            r_to_cnt     <= '0;
            r_state      <= ST_WAIT_ACK_LO;
          end else if (w_to_hit) begin
            r_data_ready  <= 1'b0;
            r_timeout_err <= 1'b1;
            r_state       <= ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        ST_WAIT_ACK_LO: begin
          if (!w_ack_s) begin
            r_bit_cnt   <= r_bit_cnt - 1'b1;
            r_setup_cnt <= '0;
            r_to_cnt    <= '0;
            // The final shift is skipped so data_bit only moves on SETUP entry.
            if (r_bit_cnt == BC_LAST) begin
              r_done  <= 1'b1;
              r_state <= ST_FINISH;
            end else begin
              r_shift <= {r_shift[WORD_W-2:0], 1'b0};
              r_state <= ST_SETUP;
            end
          end else if (w_to_hit) begin
            r_timeout_err <= 1'b1;
            r_state       <= ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        ST_FINISH: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign word_ready  = (r_state == ST_IDLE);
  assign data_ready  = r_data_ready;
  assign data_bit    = r_shift[WORD_W-1];
  assign done        = r_done;
  assign timeout_err = r_timeout_err;
  assign tx_state    = r_state;

endmodule

// File: tb/tb_instr_serial_tx.sv
// Scoreboard bench for instr_serial_tx with a delayed-ack receiver model.
module tb_instr_serial_tx;

  localparam int WORD_W       = 10;
  localparam int SETUP_CYCLES = 4;
  localparam int ACK_TIMEOUT  = 100;
  localparam int ACK_DLY      = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [WORD_W-1:0] word_in = '0;
  logic              word_valid = 1'b0;
  logic              word_ready;
  logic              data_ack = 1'b0;
  logic              data_ready;
  logic              data_bit;
  logic              done;
  logic              timeout_err;
  logic [2:0]        tx_state;

  instr_serial_tx #(
    .WORD_W       (WORD_W),
    .SETUP_CYCLES (SETUP_CYCLES),
    .ACK_TIMEOUT  (ACK_TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .data_ack    (data_ack),
    .data_ready  (data_ready),
    .data_bit    (data_bit),
    .done        (done),
    .timeout_err (timeout_err),
    .tx_state    (tx_state)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  logic exp_q[$];
  int   cyc = 0, rises = 0, dones = 0, touts = 0;
  int   rise_cyc = 0, to_lat = -1, setup_run = 0, last_setup = 0;
  logic prev_dr = 1'b0, prev_bit = 1'b0;
  bit   chk_setup_len = 1'b1;
  int   ack_given = 0, ack_limit = 1000;
  int   rx_phase = 0, rx_dly = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: bit scoreboard, setup length, stability and pulse accounting.
  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        prev_dr   = 1'b0;
        prev_bit  = 1'b0;
        setup_run = 0;
      end else begin
        if (tx_state == 3'd1) setup_run++;
        else if (setup_run != 0) begin
          last_setup = setup_run;
          setup_run  = 0;
        end
        if (data_bit !== prev_bit) check_val("dbit_chg_while_dr", data_ready, 0);
        if (data_ready && !prev_dr) begin
          rises++;
          rise_cyc = cyc;
          if (chk_setup_len) check_val("setup_len", last_setup, SETUP_CYCLES);
          check_val("sb_nonempty", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check_val("bit", data_bit, exp_q.pop_front());
        end
        if (done) dones++;
        if (timeout_err) begin
          touts++;
          to_lat = cyc - rise_cyc;
        end
        if (done || timeout_err) check_val("done_to_excl", done & timeout_err, 0);
        prev_dr  = data_ready;
        prev_bit = data_bit;
      end
    end
  end

  // Receiver: acks ACK_DLY cycles after data_ready rises, releases when it falls.
  initial begin : receiver
    forever begin
      @(negedge clk);
      if (!reset) begin
        rx_phase = 0;
        data_ack = 1'b0;
      end else begin
        case (rx_phase)
          0: if (data_ready && ack_given < ack_limit) begin
               rx_phase = 1;
               rx_dly   = 0;
             end
          1: begin
               rx_dly++;
               if (rx_dly == ACK_DLY) begin
                 data_ack = 1'b1;
                 rx_phase = 2;
               end
             end
          default: if (!data_ready) begin
               data_ack = 1'b0;
               ack_given++;
               rx_phase = 0;
             end
        endcase
      end
    end
  end

  task automatic send_word(input logic [WORD_W-1:0] w);
    int t = 0;
    @(negedge clk);
    while (!word_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check_val("word_ready_wait", word_ready, 1);
    word_in    = w;
    word_valid = 1'b1;
    for (int i = WORD_W - 1; i >= 0; i--) exp_q.push_back(w[i]);
    @(posedge clk);
    #1;
    word_valid = 1'b0;
    word_in    = ~w;
  endtask

  task automatic wait_end(input int base_done, input int base_to);
    int t = 0;
    while (dones == base_done && touts == base_to && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check_val("end_seen", (dones != base_done) || (touts != base_to), 1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int r0, d0, t0, t, n_acc;

    repeat (3) @(negedge clk);
    #1;
    check_val("rst_data_ready", data_ready, 0);
    check_val("rst_data_bit", data_bit, 0);
    check_val("rst_done", done, 0);
    check_val("rst_timeout", timeout_err, 0);
    check_val("rst_state", tx_state, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("rst_word_ready", word_ready, 1);

    // Basic word, 3-cycle ack receiver.
    ack_given = 0; r0 = rises; d0 = dones; t0 = touts;
    send_word(10'b11_1000_0001);
    wait_end(d0, t0);
    check_val("w1_handshakes", rises - r0, 10);
    check_val("w1_done", dones - d0, 1);
    check_val("w1_no_to", touts - t0, 0);
    check_val("w1_sb_empty", exp_q.size(), 0);
    @(negedge clk);
    check_val("w1_word_ready", word_ready, 1);

    // Receiver stops acking after bit 4.
    ack_given = 0; ack_limit = 4; r0 = rises; d0 = dones; t0 = touts;
    send_word(10'h2C5);
    wait_end(d0, t0);
    check_val("to_pulse", touts - t0, 1);
    check_val("to_latency", to_lat, ACK_TIMEOUT);
    check_val("to_no_done", dones - d0, 0);
    check_val("to_data_ready", data_ready, 0);
    check_val("to_state", tx_state, 0);
    check_val("to_acks", ack_given, 4);
    check_val("to_rises", rises - r0, 5);
    check_val("to_sb_left", exp_q.size(), 5);
    exp_q.delete();
    ack_limit = 1000;

    // Ack stuck high at start of word.
    ack_given = 0; data_ack = 1'b1;
    repeat (5) @(negedge clk);
    chk_setup_len = 1'b0; r0 = rises; d0 = dones; t0 = touts;
    send_word(10'h0F3);
    repeat (30) @(negedge clk);
    check_val("stuck_no_rise", rises - r0, 0);
    check_val("stuck_dr", data_ready, 0);
    check_val("stuck_state", tx_state, 1);
    data_ack = 1'b0;
    wait_end(d0, t0);
    chk_setup_len = 1'b1;
    check_val("stuck_done", dones - d0, 1);
    check_val("stuck_no_to", touts - t0, 0);
    check_val("stuck_rises", rises - r0, 10);
    check_val("stuck_sb_empty", exp_q.size(), 0);

    // Reset during WAIT_ACK_HI of bit 6.
    ack_given = 0; r0 = rises; d0 = dones; t0 = touts;
    send_word(10'h3B6);
    t = 0;
    while (!((rises - r0) >= 6 && tx_state == 3'd2) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check_val("mid_reached", (rises - r0) >= 6 && tx_state == 3'd2, 1);
    check_val("mid_pre_dr", data_ready, 1);
    check_val("mid_pre_bit", data_bit, 1);
    reset = 1'b0;
    data_ack = 1'b0;
    #1;
    check_val("mid_rst_dr", data_ready, 0);
    check_val("mid_rst_bit", data_bit, 0);
    check_val("mid_rst_done", done, 0);
    check_val("mid_rst_to", timeout_err, 0);
    check_val("mid_rst_state", tx_state, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    check_val("mid_silent_done", dones - d0, 0);
    check_val("mid_silent_to", touts - t0, 0);
    reset = 1'b1;
    @(negedge clk);
    check_val("mid_word_ready", word_ready, 1);
    r0 = rises;
    send_word(10'h155);
    wait_end(d0, t0);
    check_val("post_done", dones - d0, 1);
    check_val("post_no_to", touts - t0, 0);
    check_val("post_rises", rises - r0, 10);
    check_val("post_sb_empty", exp_q.size(), 0);

    // Back-to-back with word_valid held and word_in changing every cycle.
    d0 = dones; t0 = touts; n_acc = 0; t = 0;
    word_in = WORD_W'($urandom);
    word_valid = 1'b1;
    while (n_acc < 3 && t < 5000) begin
      @(negedge clk);
      t++;
      if (word_ready) begin
        for (int i = WORD_W - 1; i >= 0; i--) exp_q.push_back(word_in[i]);
        n_acc++;
      end
      @(posedge clk);
      #1;
      if (n_acc == 3) word_valid = 1'b0;
      word_in = WORD_W'($urandom);
    end
    check_val("b2b_accepted", n_acc, 3);
    t = 0;
    while ((dones - d0) < 3 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (20) @(negedge clk);
    check_val("b2b_done", dones - d0, 3);
    check_val("b2b_no_to", touts - t0, 0);
    check_val("b2b_sb_empty", exp_q.size(), 0);
    check_val("b2b_idle", word_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
